sdwr_serial_tx: RTL and testbench
=================================

Name: sdwr_serial_tx

Overview:
Bus-addressed serial transmitter: the write-direction counterpart of the serial read (SDRD) responder. A byte written by the host into the select window (SSER low, BA13=0, BA12=1) goes into a holding register, then a shift register. It is sent on SDWR as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, 1 stop bit. Status is readable over the same window.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; legal range 2..255
DIV_W, 8, width of the bit-period counter; must satisfy 2^DIV_W > CLK_DIV

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
SSER  in  1  active-low serial-port select
BA  in  14  bus address; only BA13, BA12 and BA7..BA4 are decoded
BR_W  in  1  bus direction: 1 = read, 0 = write
bus_stb  in  1  one-cycle access strobe; qualifies writes and side effects
BD_IN  in  8  write data from bus
BD_OUT  out  8  read data to bus
BD_OE  out  1  read-data drive enable
SDWR  out  1  serial data out; idle high
tx_busy  out  1  high while a frame is in progress or the holding register is full

Behaviour:
- Decode: sel = ~SSER & ~BA13 & BA12. reg = BA[7:4]. Accesses with BA[7:4] not 0, 1 or 2 are ignored; reads of them return 0x00.
- Reg 0, write (DATA): load holding register (hold_full <= 1). If hold_full is already 1 and it is not being emptied this cycle, drop the byte and set overrun.
- Reg 1, read (STATUS): bit0 = frame active, bit1 = hold_full, bit2 = overrun, bit3 = par_en, bits7..4 = 0.
- Reg 2, write (CTRL): bit0 = 1 clears overrun (write-one-to-clear). bit1 -> par_en.
- BD_OE = sel & BR_W, combinational. BD_OUT is combinational and 0x00 when BD_OE=0. A read has no side effects and needs no strobe.
- Writes act only on a clk edge with sel & ~BR_W & bus_stb.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when hold_full: same edge copies holding to shifter, clears hold_full, latches par_en into frame_par, resets bitcnt, divcnt=0, SDWR=0.
  - Every state holds for exactly CLK_DIV cycles (divcnt 0..CLK_DIV-1). Transitions occur on the edge where divcnt=CLK_DIV-1.
  - START -> DATA: SDWR=shift[0].
  - DATA: 8 bit periods; shift right each period end. After bit 7, go to PARITY if frame_par, else STOP.
  - PARITY: SDWR = XOR of the 8 data bits (even parity).
  - STOP: SDWR=1. At end, go to START if hold_full (back-to-back, no idle gap), else IDLE.
- Latency: a DATA write sampled at edge N while IDLE gives hold_full=1 after N and SDWR=0 from edge N+1.
- Frame length: 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
- Simultaneous DATA write and holding->shifter transfer on the same edge: the write lands in holding (hold_full stays 1) and overrun is not set.
- Simultaneous overrun-set and CTRL clear on the same edge: set wins.
- A par_en change mid-frame affects only the next frame.
- tx_busy = (state != IDLE) | hold_full, registered-state derived.
- Reset (any cycle, including mid-frame): state=IDLE, SDWR=1, hold_full=0, overrun=0, par_en=0, divcnt=bitcnt=0, tx_busy=0.
- BD_OUT/BD_OE remain purely combinational from inputs and state.
- divcnt and bitcnt never wrap outside their terminal counts. Data bits are emitted strictly LSB first.

Test Plan:
- Reset then idle: rst high 2 cycles -> SDWR=1, tx_busy=0, STATUS read (BA=0x1010, BR_W=1) returns 0x00, BD_OE=1.
- Single frame, CLK_DIV=4, no parity: write 0xA5 to reg 0 -> starting 1 cycle after the strobe edge, SDWR = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles (40 cycles total); tx_busy drops after the stop bit.
- Parity: CTRL write 0x02, then DATA 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1; frame 44 cycles.
- Back-to-back and overrun: write 0x11, then 0x22 during the start bit, then 0x33 while holding is full -> frames 0x11 then 0x22 with no idle gap; 0x33 never sent; STATUS bit2=1. CTRL write 0x01 -> STATUS bit2=0.
- Decode rejection: write 0x55 with SSER=1, with BA13=1, with BA12=0, and with BA[7:4]=5 -> no frame sent, hold_full stays 0, BD_OE=0 in the first three cases.
- Reset mid-frame: assert rst during data bit 3 of 0xF0 with holding full -> SDWR=1 the next cycle, STATUS=0x00 after release, no further frame.

Source files
------------

// File: rtl/sdwr_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sdwr_serial_tx
//  Description : Bus-addressed serial transmitter. A byte written into the
//                select window is held, copied into a shifter and sent on SDWR
//                as start + 8 data bits (LSB first) + optional even parity +
//                stop. Status and control share the same window.
//  Revision    : 1.0  initial release
// ============================================================================
module sdwr_serial_tx #(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SSER,
    input  logic [13:0] BA,
    input  logic        BR_W,
    input  logic        bus_stb,
    input  logic [7:0]  BD_IN,
    output logic [7:0]  BD_OUT,
    output logic        BD_OE,
    output logic        SDWR,
    output logic        tx_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       c_reg_data = 4'd0;
    localparam logic [3:0]       c_reg_stat = 4'd1;
    localparam logic [3:0]       c_reg_ctrl = 4'd2;

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_divcnt;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_par_bit;
    logic             r_frame_par;
    logic             r_sdwr;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_overrun;
    logic             r_par_en;

    logic       w_sel;
    logic [3:0] w_reg;
    logic       w_wr;
    logic       w_wr_data;
    logic       w_wr_ctrl;
    logic       w_div_end;
    logic       w_xfer;
    logic       w_active;
    logic       w_unused_ba;

    assign w_sel       = ~SSER & ~BA[13] & BA[12];
    assign w_reg       = BA[7:4];
    assign w_wr        = w_sel & ~BR_W & bus_stb;
    assign w_wr_data   = w_wr & (w_reg == c_reg_data);
    assign w_wr_ctrl   = w_wr & (w_reg == c_reg_ctrl);
    assign w_div_end   = (r_divcnt == c_div_last);
    assign w_active    = (r_state != S_IDLE);
    // Holding register empties into the shifter from IDLE, or at the end of
    // STOP so consecutive frames run with no idle gap.
    assign w_xfer      = r_hold_full &
                         ((r_state == S_IDLE) | ((r_state == S_STOP) & w_div_end));
    assign w_unused_ba = ^{BA[11:8], BA[3:0]};

    assign BD_OE   = w_sel & BR_W;
    assign SDWR    = r_sdwr;
    assign tx_busy = w_active | r_hold_full;

    // Read mux: only STATUS returns data, everything else reads as zero.
    always_comb begin
        BD_OUT = 8'h00;
        if (BD_OE && (w_reg == c_reg_stat)) begin
            BD_OUT = {4'b0000, r_par_en, r_overrun, r_hold_full, w_active};
        end
    end

    // Holding register and overrun flag; a write coincident with the transfer
    // lands safely because the old byte is leaving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_wr_data && (!r_hold_full || w_xfer)) begin
                r_hold      <= BD_IN;
                r_hold_full <= 1'b1;
            end else if (w_xfer) begin
                r_hold_full <= 1'b0;
            end
            // Setting overrun takes priority over a same-edge clear.
            if (w_wr_data && r_hold_full && !w_xfer) begin
                r_overrun <= 1'b1;
            end else if (w_wr_ctrl && BD_IN[0]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Parity enable control bit; sampled into the frame at load time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_par_en <= BD_IN[1];
        end
    end

    // Frame sequencer: each non-idle state lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_divcnt    <= '0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_par_bit   <= 1'b0;
            r_frame_par <= 1'b0;
            r_sdwr      <= 1'b1;
        end else if (w_xfer) begin
            r_state     <= S_START;
            r_shift     <= r_hold;
            r_par_bit   <= ^r_hold;
            r_frame_par <= r_par_en;
            r_bitcnt    <= 3'd0;
            r_divcnt    <= '0;
            r_sdwr      <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (w_div_end) begin
                r_divcnt <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_sdwr  <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bitcnt == 3'd7) begin
                            if (r_frame_par) begin
                                r_state <= S_PARITY;
                                r_sdwr  <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_sdwr  <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_sdwr   <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_sdwr  <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sdwr  <= 1'b1;
                    end
                endcase
            end else begin
                r_divcnt <= r_divcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdwr_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdwr_serial_tx
//  Description : Self-checking bench for sdwr_serial_tx with a frame
//                scoreboard and directed decode / overrun / reset scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdwr_serial_tx;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SSER = 1'b1;
    logic [13:0] BA = 14'h0000;
    logic        BR_W = 1'b1;
    logic        bus_stb = 1'b0;
    logic [7:0]  BD_IN = 8'h00;
    logic [7:0]  BD_OUT;
    logic        BD_OE;
    logic        SDWR;
    logic        tx_busy;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     frames = 0;
    int     start_cyc [0:7];
    logic   mon_en = 1'b0;
    logic   mon_busy = 1'b0;
    frame_t sb_q [$];

    sdwr_serial_tx #(.CLK_DIV(CLK_DIV), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .SSER(SSER), .BA(BA), .BR_W(BR_W),
        .bus_stb(bus_stb), .BD_IN(BD_IN), .BD_OUT(BD_OUT), .BD_OE(BD_OE),
        .SDWR(SDWR), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One bus write through the window; returns #1 after the sampling edge.
    task automatic bus_wr(input logic sser, input logic [13:0] ba, input logic [7:0] d);
        @(negedge clk);
        SSER = sser; BA = ba; BR_W = 1'b0; BD_IN = d; bus_stb = 1'b1;
        @(posedge clk);
        #1;
        SSER = 1'b1; BR_W = 1'b1; bus_stb = 1'b0; BA = 14'h0000;
    endtask

    task automatic rd_status(output logic [7:0] v, output logic oe);
        SSER = 1'b0; BA = 14'h1010; BR_W = 1'b1;
        #1;
        v = BD_OUT; oe = BD_OE;
        SSER = 1'b1; BA = 14'h0000;
    endtask

    task automatic push_data(input logic [7:0] d, input logic p);
        frame_t f;
        f.d = d; f.p = p;
        sb_q.push_back(f);
    endtask

    task automatic wait_idle(input int limit, output int end_cyc);
        int n;
        n = 0;
        end_cyc = -1;
        while (n < limit) begin
            @(negedge clk);
            if (!tx_busy && !mon_busy) begin
                end_cyc = cyc;
                break;
            end
            n++;
        end
        if (end_cyc < 0) check_eq("idle_timeout", 1, 0);
    endtask

    // Line monitor: captures every frame cycle by cycle and compares with the
    // oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && SDWR === 1'b0) begin
                frame_t      f;
                logic [10:0] got, expv;
                logic        glitch;
                int          nb;
                mon_busy = 1'b1;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                    f.d = 8'h00; f.p = 1'b0;
                end else begin
                    f = sb_q.pop_front();
                end
                if (frames < 8) start_cyc[frames] = cyc;
                nb = f.p ? 11 : 10;
                expv = '0;
                expv[8:1] = f.d;
                if (f.p) begin
                    expv[9]  = ^f.d;
                    expv[10] = 1'b1;
                end else begin
                    expv[9] = 1'b1;
                end
                got = '0;
                glitch = 1'b0;
                for (int c = 0; c < nb * CLK_DIV; c++) begin
                    if (c > 0) @(negedge clk);
                    if (c % CLK_DIV == 0) got[c / CLK_DIV] = SDWR;
                    else if (SDWR !== got[c / CLK_DIV]) glitch = 1'b1;
                end
                check_eq("frame_bits", {21'd0, got}, {21'd0, expv});
                check_eq("bit_stable", {31'd0, glitch}, 0);
                frames++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] st;
        logic       oe;
        int         wr_cyc, end_cyc, zeros;

        // Reset and idle state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_sdwr", {31'd0, SDWR}, 1);
        check_eq("rst_busy", {31'd0, tx_busy}, 0);
        rd_status(st, oe);
        check_eq("rst_status", {24'd0, st}, 8'h00);
        check_eq("rst_oe", {31'd0, oe}, 1);
        mon_en = 1'b1;

        // Single frame, no parity, with exact latency and length
        push_data(8'hA5, 1'b0);
        bus_wr(1'b0, 14'h1000, 8'hA5);
        wr_cyc = cyc;
        check_eq("lat_sdwr_hi", {31'd0, SDWR}, 1);
        check_eq("lat_busy", {31'd0, tx_busy}, 1);
        @(posedge clk);
        #1;
        check_eq("lat_start", {31'd0, SDWR}, 0);
        wait_idle(200, end_cyc);
        check_eq("len_10bit", end_cyc - wr_cyc, 1 + 10 * CLK_DIV);

        // Parity frame
        bus_wr(1'b0, 14'h1020, 8'h02);
        rd_status(st, oe);
        check_eq("par_status", {24'd0, st}, 8'h08);
        push_data(8'h07, 1'b1);
        bus_wr(1'b0, 14'h1000, 8'h07);
        wr_cyc = cyc;
        wait_idle(200, end_cyc);
        check_eq("len_11bit", end_cyc - wr_cyc, 1 + 11 * CLK_DIV);

        // Back-to-back, same-edge write+transfer, then overrun
        bus_wr(1'b0, 14'h1020, 8'h00);
        push_data(8'h11, 1'b0);
        bus_wr(1'b0, 14'h1000, 8'h11);
        push_data(8'h22, 1'b0);
        bus_wr(1'b0, 14'h1000, 8'h22);
        bus_wr(1'b0, 14'h1000, 8'h33);
        rd_status(st, oe);
        check_eq("ovr_status", {24'd0, st}, 8'h07);
        wait_idle(300, end_cyc);
        check_eq("b2b_frames", frames, 4);
        check_eq("b2b_gap", start_cyc[3] - start_cyc[2], 10 * CLK_DIV);
        rd_status(st, oe);
        check_eq("ovr_sticky", {24'd0, st}, 8'h04);
        bus_wr(1'b0, 14'h1020, 8'h01);
        rd_status(st, oe);
        check_eq("ovr_clear", {24'd0, st}, 8'h00);

        // Decode rejection
        begin
            logic        t_sser [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
            logic [13:0] t_ba   [4] = '{14'h1000, 14'h3000, 14'h0000, 14'h1050};
            logic        t_oe   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 4; i++) begin
                SSER = t_sser[i]; BA = t_ba[i]; BR_W = 1'b1;
                #1;
                check_eq("dec_oe", {31'd0, BD_OE}, {31'd0, t_oe[i]});
                check_eq("dec_rd0", {24'd0, BD_OUT}, 0);
                SSER = 1'b1; BA = 14'h0000;
                bus_wr(t_sser[i], t_ba[i], 8'h55);
                repeat (3) @(posedge clk);
                #1;
                check_eq("dec_busy", {31'd0, tx_busy}, 0);
                rd_status(st, oe);
                check_eq("dec_status", {24'd0, st}, 8'h00);
            end
        end

        // Reset during data bit 3 with the holding register full
        mon_en = 1'b0;
        bus_wr(1'b0, 14'h1000, 8'hF0);
        bus_wr(1'b0, 14'h1000, 8'h99);
        repeat (17) @(posedge clk);
        #1;
        check_eq("mid_bit3", {31'd0, SDWR}, 0);
        rd_status(st, oe);
        check_eq("mid_status", {24'd0, st}, 8'h03);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mrst_sdwr", {31'd0, SDWR}, 1);
        check_eq("mrst_busy", {31'd0, tx_busy}, 0);
        rst = 1'b0;
        rd_status(st, oe);
        check_eq("mrst_status", {24'd0, st}, 8'h00);
        zeros = 0;
        repeat (60) begin
            @(negedge clk);
            if (SDWR !== 1'b1) zeros++;
        end
        check_eq("mrst_no_frame", zeros, 0);

        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("frame_count", frames, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
